// File: rtl/dcache_responder_pkg.sv
// Shared RV32I types; this slice adds the data-cache responder state, line type and geometry.
package rv32i_types;

    localparam int DCACHE_S_OFFSET = 5;
    localparam int DCACHE_S_INDEX  = 3;

    typedef logic [255:0] dcache_line_t;

    typedef enum logic [1:0] {
        CHECK = 2'd0,
        WB    = 2'd1,
        FILL  = 2'd2
    } dcache_state_t;

    // Spread one word's four byte lanes onto the 32 byte lanes of a line.
    function automatic logic [31:0] dcache_byte_en(input logic [3:0] be, input logic [2:0] word);
        return {28'd0, be} << {word, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Line storage for the data cache: flop array, combinational read, per-byte or whole-line write.
module dcache_data_array
    import rv32i_types::*;
#(
    parameter int S_INDEX = DCACHE_S_INDEX
) (
    input  logic               clk_i,
    input  logic [S_INDEX-1:0] index_i,
    input  logic               write_line_i,
    input  logic [31:0]        byte_en_i,
    input  dcache_line_t       data_i,
    output dcache_line_t       data_o
);

    dcache_line_t lines_q [2**S_INDEX];

    // A line strobe overrides the byte enables so a fill replaces the whole line.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 32; b++) begin
            if (write_line_i || byte_en_i[b]) begin
                lines_q[index_i][8*b +: 8] <= data_i[8*b +: 8];
            end
        end
    end

    assign data_o = lines_q[index_i];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate data cache answering the MEM stage over a pmem burst port.
// Optional hit/miss counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache_responder
    import rv32i_types::*;
#(
    parameter int S_INDEX  = DCACHE_S_INDEX,
    parameter int S_OFFSET = DCACHE_S_OFFSET
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int TAG_W = 32 - S_INDEX - S_OFFSET;
    localparam int SETS  = 2**S_INDEX;

    dcache_state_t          state_q;
    logic [TAG_W-1:0]       tag_q [SETS];
    logic [SETS-1:0]        valid_q;
    logic [SETS-1:0]        dirty_q;
    logic [31-S_OFFSET:0]   miss_line_q;
    logic                   pmem_read_q;
    logic                   pmem_write_q;
    logic [31:0]            pmem_address_q;

    logic                   req_s;
    logic                   hit_s;
    logic                   miss_s;
    logic [TAG_W-1:0]       req_tag_s;
    logic [S_INDEX-1:0]     req_idx_s;
    logic [S_OFFSET-3:0]    word_s;
    logic [TAG_W-1:0]       miss_tag_s;
    logic [S_INDEX-1:0]     miss_idx_s;
    logic [S_INDEX-1:0]     arr_idx_s;
    logic                   arr_write_line_s;
    logic [31:0]            arr_byte_en_s;
    dcache_line_t           arr_din_s;
    dcache_line_t           arr_line_s;
    logic                   unused_s;

    assign req_s      = mem_read | mem_write;
    assign req_tag_s  = mem_address[31:S_INDEX+S_OFFSET];
    assign req_idx_s  = mem_address[S_INDEX+S_OFFSET-1:S_OFFSET];
    assign word_s     = mem_address[S_OFFSET-1:2];
    assign miss_tag_s = miss_line_q[31-S_OFFSET:S_INDEX];
    assign miss_idx_s = miss_line_q[S_INDEX-1:0];
    assign unused_s   = ^mem_address[1:0];

    assign hit_s  = (state_q == CHECK) && req_s && valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);
    assign miss_s = (state_q == CHECK) && req_s && !hit_s;

    // While a miss is outstanding the array follows the latched line, not the live request.
    assign arr_idx_s = (state_q == CHECK) ? req_idx_s : miss_idx_s;

    // Array write port: fills replace the line, store hits merge enabled bytes.
    always_comb begin
        arr_write_line_s = 1'b0;
        arr_byte_en_s    = 32'd0;
        arr_din_s        = {8{mem_wdata}};
        if (!rst) begin
            arr_write_line_s = 1'b0;
        end else if (state_q == FILL && pmem_resp) begin
            arr_write_line_s = 1'b1;
            arr_din_s        = pmem_rdata;
        end else if (hit_s && mem_write) begin
            arr_byte_en_s = dcache_byte_en(mem_byte_enable, word_s);
        end else begin
            arr_byte_en_s = 32'd0;
        end
    end

    dcache_data_array #(.S_INDEX(S_INDEX)) u_data (
        .clk_i        (clk),
        .index_i      (arr_idx_s),
        .write_line_i (arr_write_line_s),
        .byte_en_i    (arr_byte_en_s),
        .data_i       (arr_din_s),
        .data_o       (arr_line_s)
    );

    // Controller: miss detection, writeback/fill sequencing and valid/dirty bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= CHECK;
            valid_q        <= '0;
            dirty_q        <= '0;
            miss_line_q    <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= 32'd0;
        end else begin
            case (state_q)
                CHECK: begin
                    if (miss_s) begin
                        miss_line_q <= mem_address[31:S_OFFSET];
                        if (valid_q[req_idx_s] && dirty_q[req_idx_s]) begin
                            state_q        <= WB;
                            pmem_write_q   <= 1'b1;
                            pmem_address_q <= {tag_q[req_idx_s], req_idx_s, {S_OFFSET{1'b0}}};
                        end else begin
                            state_q        <= FILL;
                            pmem_read_q    <= 1'b1;
                            pmem_address_q <= {mem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
                        end
                    end else if (hit_s && mem_write && (mem_byte_enable != 4'd0)) begin
                        dirty_q[req_idx_s] <= 1'b1;
                    end
                end
                WB: begin
                    if (pmem_resp) begin
                        state_q        <= FILL;
                        pmem_write_q   <= 1'b0;
                        pmem_read_q    <= 1'b1;
                        pmem_address_q <= {miss_line_q, {S_OFFSET{1'b0}}};
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        state_q                <= CHECK;
                        pmem_read_q            <= 1'b0;
                        pmem_address_q         <= 32'd0;
                        valid_q[miss_idx_s]    <= 1'b1;
                        dirty_q[miss_idx_s]    <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= CHECK;
                    pmem_read_q    <= 1'b0;
                    pmem_write_q   <= 1'b0;
                    pmem_address_q <= 32'd0;
                end
            endcase
        end
    end

    // Tags are not reset: valid bits alone decide whether a tag means anything.
    always_ff @(posedge clk) begin
        if (rst && state_q == FILL && pmem_resp) begin
            tag_q[miss_idx_s] <= miss_tag_s;
        end
    end

    assign mem_resp     = hit_s;
    assign mem_rdata    = (hit_s && mem_read && !mem_write) ? arr_line_s[{word_s, 5'd0} +: 32] : 32'd0;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_write_q ? arr_line_s : 256'd0;

`ifdef DCACHE_PERF_CNT_EN
    logic        fill_seen_q;
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    // A response that follows a fill is not a hit; both counters saturate.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_seen_q  <= 1'b0;
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else if (miss_s) begin
            fill_seen_q <= 1'b1;
            if (miss_count_q != 32'hFFFF_FFFF) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end else if (hit_s) begin
            fill_seen_q <= 1'b0;
            if (!fill_seen_q && hit_count_q != 32'hFFFF_FFFF) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
        end else if (state_q == CHECK) begin
            fill_seen_q <= 1'b0;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

    dcache_responder_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_resp   (mem_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .in_check   (state_q == CHECK)
    );

endmodule

// Protocol checks on the pipeline and pmem sides of the responder.
module dcache_responder_chk (
    input logic clk,
    input logic rst,
    input logic mem_read,
    input logic mem_write,
    input logic mem_resp,
    input logic pmem_read,
    input logic pmem_write,
    input logic in_check
);

    a_rw_illegal: assert property (@(posedge clk) disable iff (!rst) !(mem_read && mem_write))
        else $error("dcache_responder: mem_read and mem_write asserted together");

    a_pmem_excl: assert property (@(posedge clk) disable iff (!rst) !(pmem_read && pmem_write))
        else $error("dcache_responder: pmem_read and pmem_write asserted together");

    a_resp_check: assert property (@(posedge clk) disable iff (!rst) mem_resp |-> in_check)
        else $error("dcache_responder: mem_resp outside CHECK");

endmodule

// File: tb/tb_dcache_responder.sv
// Directed plus random bench for dcache_responder against a flat-memory reference model.
module tb_dcache_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    // Reference model: coherent program view (gold), backing memory (bk), and per-set residency.
    logic [31:0] gold [int unsigned];
    logic [31:0] bk   [int unsigned];
    bit          m_valid [8];
    bit          m_dirty [8];
    logic [23:0] m_tag   [8];

    always #5 clk = ~clk;

    dcache_responder dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [31:0] bk_word(input logic [31:0] a);
        if (bk.exists(a)) return bk[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] gold_word(input logic [31:0] a);
        if (gold.exists(a)) return gold[a];
        return bk_word(a);
    endfunction

    function automatic logic [255:0] gold_line(input logic [31:0] base);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = gold_word(base + 32'(4*w));
        return l;
    endfunction

    function automatic logic [255:0] bk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = bk_word(base + 32'(4*w));
        return l;
    endfunction

    // Reset discards dirty data: the program view falls back to backing memory.
    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            if (m_valid[s] && m_dirty[s]) begin
                for (int w = 0; w < 8; w++) begin
                    logic [31:0] a;
                    a = {m_tag[s], 3'(s), 3'(w), 2'b00};
                    if (gold.exists(a)) gold.delete(a);
                end
            end
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // One pipeline request, serviced by an in-bench pmem responder with fixed latency.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input int lat, output logic [31:0] rd);
        int          set;
        logic [23:0] tag;
        bit          hit, wb, done;
        int          exp_k, k, pw, pr;
        logic [31:0] line_a, victim_a, wa, v;
        set      = int'(addr[7:5]);
        tag      = addr[31:8];
        wa       = {addr[31:2], 2'b00};
        line_a   = {addr[31:5], 5'd0};
        hit      = m_valid[set] && (m_tag[set] == tag);
        wb       = !hit && m_valid[set] && m_dirty[set];
        victim_a = {m_tag[set], 3'(set), 5'd0};
        exp_k    = hit ? 0 : (wb ? 2*lat + 1 : lat + 1);
        if (hit) exp_hits++; else exp_misses++;
        mem_read = !wr; mem_write = wr; mem_address = addr;
        mem_byte_enable = be; mem_wdata = wd;
        k = 0; pw = 0; pr = 0; done = 1'b0; rd = 32'd0;
        while (!done && k < 64) begin
            #1;
            pmem_resp = 1'b0;
            check("pmem_rw_excl", 256'(pmem_read & pmem_write), 256'd0);
            if (pmem_write) begin
                if (pw == 0) begin
                    check("wb_expected", 256'(1'b1), 256'(wb));
                    check("wb_addr", 256'(pmem_address), 256'(victim_a));
                    check("wb_data", pmem_wdata, gold_line(victim_a));
                end
                pw++;
                if (pw == lat) begin
                    for (int w = 0; w < 8; w++) bk[pmem_address + 32'(4*w)] = pmem_wdata[32*w +: 32];
                    pmem_resp = 1'b1;
                end
            end else if (pmem_read) begin
                if (pr == 0) check("fill_addr", 256'(pmem_address), 256'(line_a));
                pr++;
                if (pr == lat) begin
                    pmem_rdata = bk_line(pmem_address);
                    pmem_resp  = 1'b1;
                end
            end
            if (mem_resp) begin
                done = 1'b1;
                check("resp_latency", 256'(k), 256'(exp_k));
                if (!wr) check("load_data", 256'(mem_rdata), 256'(gold_word(wa)));
                rd = mem_rdata;
            end
            @(negedge clk);
            k++;
        end
        check("resp_seen", 256'(done), 256'(1'b1));
        pmem_resp = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        if (!hit) begin
            m_valid[set] = 1'b1; m_tag[set] = tag; m_dirty[set] = 1'b0;
        end
        if (wr && be != 4'd0) begin
            v = gold_word(wa);
            for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
            gold[wa] = v;
            m_dirty[set] = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] rd, old;
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 4'd0;
        mem_address = 32'd0; mem_wdata = 32'd0; pmem_rdata = 256'd0; pmem_resp = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst_mem_resp", 256'(mem_resp), 256'd0);
        check("rst_mem_rdata", 256'(mem_rdata), 256'd0);
        check("rst_pmem_read", 256'(pmem_read), 256'd0);
        check("rst_pmem_write", 256'(pmem_write), 256'd0);
        check("rst_pmem_addr", 256'(pmem_address), 256'd0);
        rst = 1'b1;
        @(negedge clk);

        // Cold load then repeat hit.
        bk[32'h40] = 32'hDEAD_BEEF;
        access(1'b0, 32'h0000_0040, 4'h0, 32'd0, 3, rd);
        check("cold_load_word0", 256'(rd), 256'(32'hDEAD_BEEF));
        access(1'b0, 32'h0000_0040, 4'h0, 32'd0, 3, rd);
        check("repeat_load_hit", 256'(rd), 256'(32'hDEAD_BEEF));

        // Partial store merge.
        old = gold_word(32'h44);
        access(1'b1, 32'h0000_0044, 4'b0101, 32'h1122_3344, 2, rd);
        access(1'b0, 32'h0000_0044, 4'h0, 32'd0, 2, rd);
        check("store_merge", 256'(rd), 256'({old[31:24], 8'h22, old[15:8], 8'h44}));

        // Dirty eviction of 0x40 by 0x140.
        access(1'b0, 32'h0000_0140, 4'h0, 32'd0, 2, rd);

        // Zero-byte-enable store leaves the line clean.
        access(1'b0, 32'h0000_0080, 4'h0, 32'd0, 1, rd);
        access(1'b1, 32'h0000_0080, 4'h0, 32'hFFFF_FFFF, 1, rd);
        access(1'b0, 32'h0000_0180, 4'h0, 32'd0, 2, rd);

        // Dirty 0x140, then reset in the middle of a fill.
        access(1'b1, 32'h0000_0144, 4'hF, 32'hCAFE_F00D, 1, rd);
        mem_read = 1'b1; mem_address = 32'h0000_0060;
        @(negedge clk);
        #1;
        check("fill_started", 256'(pmem_read), 256'd1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_fill_pmem_read", 256'(pmem_read), 256'd0);
        check("rst_fill_mem_resp", 256'(mem_resp), 256'd0);
        check("rst_fill_pmem_write", 256'(pmem_write), 256'd0);
        mem_read = 1'b0; rst = 1'b1;
        model_reset();
        @(negedge clk);
        access(1'b0, 32'h0000_0040, 4'h0, 32'd0, 2, rd);
        access(1'b0, 32'h0000_0144, 4'h0, 32'd0, 2, rd);

        // Random traffic over a few conflicting tags.
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 5)
              | (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 1)) << 28);
            access(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
                   int'($urandom_range(1, 4)), rd);
        end

`ifdef DCACHE_PERF_CNT_EN
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        access(1'b0, 32'h0000_0300, 4'h0, 32'd0, 2, rd);
        access(1'b0, 32'h0000_0304, 4'h0, 32'd0, 2, rd);
        access(1'b0, 32'h0000_0308, 4'h0, 32'd0, 2, rd);
        access(1'b0, 32'h0000_03A0, 4'h0, 32'd0, 2, rd);
        #1;
        check("hit_count", 256'(hit_count), 256'(exp_hits));
        check("miss_count", 256'(miss_count), 256'(exp_misses));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
Responder side of the MEM-stage data-memory interface. It services word load/store requests from the pipeline with a direct-mapped, write-back, write-allocate cache, and fetches or evicts 256-bit lines over the physical-memory (pmem) burst port. The pipeline holds each request stable and stalls until it sees mem_resp.

Parameters:
S_INDEX, 3, index bits; number of sets = 2**S_INDEX (default 8)
S_OFFSET, 5, byte-offset bits within a line; line width = 8*2**S_OFFSET = 256 bits

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset, sampled on rising clk
mem_read  in  1  load request from MEM stage
mem_write  in  1  store request from MEM stage
mem_byte_enable  in  4  store byte lanes
mem_address  in  32  byte address; low 2 bits ignored
mem_wdata  in  32  store data, lanes aligned to the address word
mem_rdata  out  32  load data, valid while mem_resp=1
mem_resp  out  1  one-cycle completion pulse
pmem_read  out  1  line-fill request
pmem_write  out  1  line-writeback request
pmem_address  out  32  line-aligned address; low S_OFFSET bits are 0
pmem_wdata  out  256  evicted line
pmem_rdata  in  256  filled line, valid with pmem_resp
pmem_resp  in  1  pmem completion pulse

Behaviour:
- Address split: tag = [31:S_INDEX+S_OFFSET], index = [S_INDEX+S_OFFSET-1:S_OFFSET], word = [S_OFFSET-1:2].
- Tag, valid and dirty are stored in flops, read combinationally. The data array is a flop array, read combinationally, with per-byte write.
- FSM states:
  - CHECK (reset state).
  - WB: pmem_write=1, pmem_address = {stored tag, index, 0}, pmem_wdata = stored line. Held until pmem_resp → FILL.
  - FILL: pmem_read=1, pmem_address = {req tag, index, 0}. Held until pmem_resp. On that edge, write the line, set valid, set tag, clear dirty → CHECK.
- CHECK, no request: idle, all outputs 0.
- CHECK, hit: mem_resp=1 combinationally in the same cycle. Load: mem_rdata = the selected word. Store: the enabled bytes are written at the clock edge and dirty is set.
- CHECK, miss:
  - valid and dirty → WB.
  - otherwise → FILL.
  - mem_resp stays 0.
- After FILL returns to CHECK, the request hits.
- Latencies:
  - Hit: 0 extra cycles.
  - Clean miss: pmem latency + 1 cycle.
  - Dirty miss: two pmem latencies + 1 cycle.
- mem_resp is never asserted outside CHECK. pmem_read and pmem_write are never both 1.
- Store with mem_byte_enable=0: hit or allocate proceeds as normal, mem_resp is pulsed, and neither data nor dirty changes.
- mem_read and mem_write both 1: illegal. The write takes priority. The simulation assertion fires.
- Request dropped mid-miss: the pmem transaction completes and the FSM returns to CHECK.
- Reset (rst=0 at an edge):
  - state=CHECK; all valid and dirty bits cleared.
  - All outputs 0 in the following cycle.
  - An in-flight pmem transaction is abandoned and dirty data is discarded.
  - Data and tag arrays are not cleared.
- The pmem responder must tolerate a dropped request.

Optional Feature:
DCACHE_PERF_CNT_EN
- Defined: adds 32-bit output counters hit_count and miss_count.
  - hit_count increments once per mem_resp that needed no fill.
  - miss_count increments once per CHECK→WB/FILL transition.
  - Both counters reset to 0 and saturate at 0xFFFFFFFF.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package rv32i_types (shared) gains:
  - dcache_state_t enum {CHECK, WB, FILL}
  - the line type, 256-bit
  - the constants DCACHE_S_OFFSET and DCACHE_S_INDEX
- One sub-module, dcache_data_array: 2**S_INDEX lines, combinational read, synchronous write. Write port takes a per-byte enable (32 bits), a write-line strobe and data-in.
- FSM, tag, valid and dirty logic stay in dcache_responder.

Test Plan:
- After reset, load 0x0000_0040: FILL with pmem_address=0x40. Return a line whose word 0 is 0xDEAD_BEEF. mem_resp on the next CHECK cycle, mem_rdata=0xDEAD_BEEF. A repeat load hits with 0 wait.
- Store 0x1122_3344, be=4'b0101, to 0x44 (hit), then load 0x44: mem_rdata = {old[31:24], 8'h22, old[15:8], 8'h44}.
- Dirty line at 0x40, then load 0x140 (same index, other tag):
  - pmem_write with pmem_address=0x40; pmem_wdata carries the stored bytes.
  - Then pmem_read with pmem_address=0x140.
  - mem_resp after both pmem_resp pulses.
- rst=0 during FILL: next cycle pmem_read=0 and mem_resp=0. Reloading 0x40 misses again because valid was cleared.
- Store with be=0 to a clean resident line, then evict it: no pmem_write, because dirty was not set.
- With DCACHE_PERF_CNT_EN: sequence miss, hit, hit, miss → hit_count=2, miss_count=2.
